// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - synchronise, debounce and gate raw buttons for the game controller
module input_conditioner #(
    parameter int N_BTN           = 7,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYC    = 250000,
    parameter int ATTACK_COOLDOWN = 5000000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] i_btn_raw,
    input  logic             i_is_gaming,
    output logic             o_right,
    output logic             o_left,
    output logic             o_squat,
    output logic             o_defend,
    output logic             o_jump,
    output logic             o_attack,
    output logic             o_select,
    output logic [N_BTN-1:0] o_btn_stable
);
    localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
    localparam int CD_W = $clog2(ATTACK_COOLDOWN + 1);

    localparam int B_RIGHT  = 0;
    localparam int B_LEFT   = 1;
    localparam int B_JUMP   = 2;
    localparam int B_SQUAT  = 3;
    localparam int B_ATTACK = 4;
    localparam int B_DEFEND = 5;
    localparam int B_SELECT = 6;

    logic [N_BTN-1:0]                  btn_in;
    logic [SYNC_STAGES-1:0][N_BTN-1:0] sync_q;
    logic [N_BTN-1:0]                  sync_out;
    logic [N_BTN-1:0]                  stable;
    logic [N_BTN-1:0]                  stable_d;
    logic [N_BTN-1:0]                  press_pulse;
    logic [DB_W-1:0]                   db_cnt [N_BTN];
    logic [CD_W-1:0]                   cd_cnt;
    logic                              attack_fire;

    assign btn_in       = ACTIVE_LOW ? ~i_btn_raw : i_btn_raw;
    assign sync_out     = sync_q[SYNC_STAGES-1];
    assign press_pulse  = stable & ~stable_d;
    assign o_btn_stable = stable;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in};
        end
    end

    // A change is accepted only after DEBOUNCE_CYC consecutive differing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                if (sync_out[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYC - 1)) begin
                    stable[i] <= ~stable[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // Presses that lose to defend or cooldown are dropped, never queued.
    assign attack_fire = i_is_gaming & press_pulse[B_ATTACK] & ~stable[B_DEFEND]
                         & (cd_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_d <= '0;
            cd_cnt   <= '0;
            o_right  <= 1'b0;
            o_left   <= 1'b0;
            o_squat  <= 1'b0;
            o_defend <= 1'b0;
            o_jump   <= 1'b0;
            o_attack <= 1'b0;
            o_select <= 1'b0;
        end else begin
            stable_d <= stable;
            o_right  <= i_is_gaming & stable[B_RIGHT] & ~stable[B_LEFT];
            o_left   <= i_is_gaming & stable[B_LEFT] & ~stable[B_RIGHT];
            o_squat  <= i_is_gaming & stable[B_SQUAT];
            o_defend <= i_is_gaming & stable[B_DEFEND];
            o_jump   <= i_is_gaming & press_pulse[B_JUMP];
            o_attack <= attack_fire;
            o_select <= ~i_is_gaming & press_pulse[B_SELECT];
            if (!i_is_gaming) begin
                cd_cnt <= '0;
            end else if (attack_fire) begin
                cd_cnt <= CD_W'(ATTACK_COOLDOWN - 1);
            end else if (cd_cnt != '0) begin
                cd_cnt <= cd_cnt - CD_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_input_conditioner.sv
// tb/tb_input_conditioner.sv - directed bench with a window-based reference model for input_conditioner
module tb_input_conditioner;
    localparam int DB = 4;
    localparam int CD = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] btn_raw = 7'h7F;
    logic       gaming = 1'b0;
    logic       o_right, o_left, o_squat, o_defend, o_jump, o_attack, o_select;
    logic [6:0] o_btn_stable;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    input_conditioner #(
        .N_BTN(7), .SYNC_STAGES(2), .DEBOUNCE_CYC(DB),
        .ATTACK_COOLDOWN(CD), .ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_btn_raw(btn_raw), .i_is_gaming(gaming),
        .o_right(o_right), .o_left(o_left), .o_squat(o_squat), .o_defend(o_defend),
        .o_jump(o_jump), .o_attack(o_attack), .o_select(o_select),
        .o_btn_stable(o_btn_stable)
    );

    // Model: h[k] is the pressed vector sampled k+1 edges ago; a bit flips once the
    // DB samples that have cleared the synchroniser all disagree with its stable value.
    logic [6:0] h [DB+1];
    logic [6:0] m_st, m_prev;
    logic [6:0] m_out;
    int         m_cyc, m_last_att;

    task automatic model_reset();
        for (int k = 0; k <= DB; k++) h[k] = '0;
        m_st = '0;
        m_prev = '0;
        m_out = '0;
        m_cyc = 0;
        m_last_att = -1000;
    endtask

    task automatic model_step();
        logic [6:0] rise, flip;
        logic r, l, sq, df, jp, at, se;
        rise = m_st & ~m_prev;
        r  = gaming & m_st[0] & !m_st[1];
        l  = gaming & m_st[1] & !m_st[0];
        sq = gaming & m_st[3];
        df = gaming & m_st[5];
        jp = gaming & rise[2];
        at = gaming & rise[4] & !m_st[5] & ((m_cyc - m_last_att) >= CD);
        if (at) m_last_att = m_cyc;
        if (!gaming) m_last_att = -1000;
        se = !gaming & rise[6];
        flip = '1;
        for (int k = 1; k <= DB; k++) flip &= (h[k] ^ m_st);
        m_prev = m_st;
        m_st = m_st ^ flip;
        for (int k = DB; k > 0; k--) h[k] = h[k-1];
        h[0] = ~btn_raw;
        m_cyc++;
        m_out = {r, l, sq, df, jp, at, se};
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("cyc_outputs", {9'd0, o_right, o_left, o_squat, o_defend, o_jump, o_attack, o_select},
              {9'd0, m_out});
        check("cyc_stable", {9'd0, o_btn_stable}, {9'd0, m_st});
    end

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
    endtask

    initial begin
        int n;
        model_reset();
        #1;
        check("reset_outs", {o_right, o_left, o_squat, o_defend, o_jump, o_attack, o_select, o_btn_stable}, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // jump pulse latency
        gaming = 1'b1;
        btn_raw[2] = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            check("t1_jump", {15'd0, o_jump}, {15'd0, i == 7});
        end
        btn_raw[2] = 1'b1;
        repeat (8) tick();

        // bouncing attack never accepted
        for (int j = 0; j < 16; j++) begin
            btn_raw[4] = (j % 4 == 3);
            tick();
            check("t2_bounce_stable", {15'd0, o_btn_stable[4]}, 16'd0);
        end
        btn_raw[4] = 1'b1;
        repeat (8) tick();

        // second press decided 9 cycles after the pulse: dropped
        n = 0;
        btn_raw[4] = 1'b0; repeat (4) begin tick(); n += int'(o_attack); end
        btn_raw[4] = 1'b1; repeat (5) begin tick(); n += int'(o_attack); end
        btn_raw[4] = 1'b0; repeat (8) begin tick(); n += int'(o_attack); end
        check("t3_cooldown_drop", 16'(n), 16'd1);
        btn_raw[4] = 1'b1;
        repeat (16) tick();

        // second press decided exactly 10 cycles after the pulse: accepted
        n = 0;
        btn_raw[4] = 1'b0; repeat (4) begin tick(); n += int'(o_attack); end
        btn_raw[4] = 1'b1; repeat (6) begin tick(); n += int'(o_attack); end
        btn_raw[4] = 1'b0; repeat (8) begin tick(); n += int'(o_attack); end
        check("t3_cooldown_edge", 16'(n), 16'd2);
        btn_raw[4] = 1'b1;
        repeat (16) tick();

        // defend held suppresses attack
        btn_raw[5] = 1'b0;
        repeat (8) tick();
        check("t3_defend_level", {15'd0, o_defend}, 16'd1);
        n = 0;
        btn_raw[4] = 1'b0; repeat (10) begin tick(); n += int'(o_attack); end
        check("t3_defend_block", 16'(n), 16'd0);
        btn_raw[5:4] = 2'b11;
        repeat (8) tick();

        // right/left conflict
        btn_raw[1:0] = 2'b00;
        repeat (10) tick();
        check("t4_stable_rl", {14'd0, o_btn_stable[1:0]}, 16'd3);
        check("t4_rl_conflict", {14'd0, o_right, o_left}, 16'd0);
        btn_raw[1] = 1'b1;
        repeat (8) tick();
        check("t4_right_after", {15'd0, o_right}, 16'd1);
        btn_raw[0] = 1'b1;
        repeat (8) tick();

        // select only outside PLAY, levels gated
        gaming = 1'b0;
        n = 0;
        btn_raw[6] = 1'b0; repeat (10) begin tick(); n += int'(o_select); end
        check("t5_select_idle", 16'(n), 16'd1);
        btn_raw[6] = 1'b1; repeat (8) tick();
        gaming = 1'b1;
        n = 0;
        btn_raw[6] = 1'b0; repeat (10) begin tick(); n += int'(o_select); end
        check("t5_select_play", 16'(n), 16'd0);
        btn_raw[6] = 1'b1; repeat (8) tick();
        gaming = 1'b0;
        btn_raw[3] = 1'b0;
        repeat (10) tick();
        check("t5_squat_gated", {15'd0, o_squat}, 16'd0);
        gaming = 1'b1;
        tick();
        check("t5_squat_play", {15'd0, o_squat}, 16'd1);
        btn_raw[3] = 1'b1;
        repeat (8) tick();

        // reset mid-cooldown and mid-debounce
        btn_raw[4] = 1'b0;
        btn_raw[0] = 1'b0;
        repeat (9) tick();
        btn_raw[2] = 1'b0;
        repeat (2) tick();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("t6_rst_outs", {o_right, o_left, o_squat, o_defend, o_jump, o_attack, o_select, o_btn_stable}, '0);
        repeat (3) tick();
        rst_n = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            check("t6_attack", {15'd0, o_attack}, {15'd0, i == 7});
        end
        btn_raw = 7'h7F;
        repeat (8) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
